// File: rtl/sb_pkg.sv
// Sideband shared definitions.
// Holds the receive FSM state encoding and the packet/gap geometry that the
// TX serializer and RX deserializer must agree on.
package sb_pkg;

  localparam int unsigned SB_PACKET_W = 64;  // bits per sideband packet
  localparam int unsigned SB_MIN_GAP  = 32;  // minimum idle UI between packets

  typedef enum logic [1:0] {
    SB_RX_IDLE,
    SB_RX_SHIFT,
    SB_RX_GAP
  } sb_rx_state_e;

endpackage

// File: rtl/sb_rx_deserializer.sv
// Sideband receive deserializer.
// Samples RXDATASB one bit per pll_clk cycle while rx_bit_valid is high, assembles
// PACKET_W-bit packets LSB-first and presents each with a one-cycle data_valid
// strobe. Enforces a MIN_GAP idle gap after each packet and flags truncated
// packets (frame_err) and early packet starts (gap_err).
//
// Ports:
//   pll_clk      in   sideband bit clock, one UI per cycle, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   receiver enable; low forces idle (synchronous)
//   RXDATASB     in   serial sideband data
//   rx_bit_valid in   a bit is present this cycle
//   data_out     out  last complete packet, bit 0 received first
//   data_valid   out  one-cycle pulse, data_out updated
//   frame_err    out  one-cycle pulse, packet truncated
//   gap_err      out  one-cycle pulse, packet started inside the idle gap
//   busy         out  high while shifting a packet
module sb_rx_deserializer
  import sb_pkg::*;
#(
  parameter int unsigned PACKET_W = SB_PACKET_W,
  parameter int unsigned MIN_GAP  = SB_MIN_GAP
) (
  input  logic                pll_clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                RXDATASB,
  input  logic                rx_bit_valid,
  output logic [PACKET_W-1:0] data_out,
  output logic                data_valid,
  output logic                frame_err,
  output logic                gap_err,
  output logic                busy
);

  localparam int unsigned BitCntW = $clog2(PACKET_W) + 1;
  localparam int unsigned GapCntW = $clog2(MIN_GAP) + 1;

  localparam logic [BitCntW-1:0] LastBit = BitCntW'(PACKET_W - 1);
  localparam logic [GapCntW-1:0] GapMax  = GapCntW'(MIN_GAP);
  localparam logic [GapCntW-1:0] GapLast = GapCntW'(MIN_GAP - 1);

  sb_rx_state_e         state_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [GapCntW-1:0]   gap_cnt_q;
  // Only the upper PACKET_W-1 bits of the shift register are ever read: the
  // oldest bit would fall off on the same edge the packet completes, so it is
  // not stored. sh_q[k] holds the bit that ends up at data_out[k+1] if no
  // further shift happened.
  logic [PACKET_W-2:0]  sh_q;
  logic [PACKET_W-1:0]  shift_in;

  assign shift_in = {RXDATASB, sh_q};
  assign busy     = (state_q == SB_RX_SHIFT);

  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SB_RX_IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      sh_q       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      gap_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      gap_err    <= 1'b0;

      if (!enable) begin
        // Abort silently; a bit offered in this cycle is dropped.
        state_q   <= SB_RX_IDLE;
        bit_cnt_q <= '0;
        gap_cnt_q <= '0;
      end else begin
        unique case (state_q)
          SB_RX_IDLE: begin
            if (rx_bit_valid) begin
              sh_q      <= shift_in[PACKET_W-1:1];
              bit_cnt_q <= BitCntW'(1);
              state_q   <= SB_RX_SHIFT;
            end
          end

          SB_RX_SHIFT: begin
            if (rx_bit_valid) begin
              sh_q <= shift_in[PACKET_W-1:1];
              if (bit_cnt_q == LastBit) begin
                data_out   <= shift_in;
                data_valid <= 1'b1;
                bit_cnt_q  <= '0;
                gap_cnt_q  <= '0;
                state_q    <= SB_RX_GAP;
              end else begin
                bit_cnt_q <= bit_cnt_q + BitCntW'(1);
              end
            end else begin
              // Truncated packet: the idle cycle that revealed it counts as gap.
              frame_err <= 1'b1;
              bit_cnt_q <= '0;
              gap_cnt_q <= GapCntW'(1);
              state_q   <= SB_RX_GAP;
            end
          end

          SB_RX_GAP: begin
            if (rx_bit_valid) begin
              // Early start is flagged but the packet is still received.
              gap_err   <= 1'b1;
              sh_q      <= shift_in[PACKET_W-1:1];
              bit_cnt_q <= BitCntW'(1);
              state_q   <= SB_RX_SHIFT;
            end else if (gap_cnt_q >= GapLast) begin
              gap_cnt_q <= GapMax;
              state_q   <= SB_RX_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + GapCntW'(1);
            end
          end

          default: begin
            state_q   <= SB_RX_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
          end
        endcase
      end
    end
  end

endmodule
